pipe_hold_ctrl: RTL and testbench

- Central hazard and stall controller for the 5-stage 64-bit pipeline.
- Drives the 2-bit hold_flag_i input of every DFF_SET-based pipeline register (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC hold/redirect.
- Sequences multi-cycle mul/div operations, data-memory wait states, branch/jump flushes and load-use bubbles.
- Keeps a stall performance counter.

---
 rtl/pipe_hold_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_hold_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hold_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: produces per-register hold codes,
// the PC hold/redirect, mul/div sequencing with timeout, and a saturating stall counter.
module pipe_hold_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int IMEM_LAT   = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_en_i,
    input  logic [63:0]      jump_addr_i,
    input  logic             load_use_i,
    input  logic             md_start_i,
    input  logic             md_done_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    input  logic             cnt_clr_i,
    output logic             hold_pc_o,
    output logic             pc_jump_en_o,
    output logic [63:0]      pc_jump_addr_o,
    output logic [1:0]       hold_if_id_o,
    output logic [1:0]       hold_id_ex_o,
    output logic [1:0]       hold_ex_mem_o,
    output logic [1:0]       hold_mem_wb_o,
    output logic             md_abort_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [1:0]  HC_NORMAL  = 2'b00;
    localparam logic [1:0]  HC_HOLD    = 2'b01;
    localparam logic [1:0]  HC_FLUSH   = 2'b10;
    localparam logic [15:0] TIMER_LAST = 16'(MD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MD_BUSY,
        ST_JFLUSH
    } state_t;

    state_t           state_reg, state_next;
    logic [15:0]      md_timer_reg, md_timer_next;
    logic             md_done_q_reg, md_done_q_next;
    logic             md_abort_reg, md_abort_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic             mem_wait;
    logic             md_done_any;

    assign mem_wait       = mem_req_i & ~mem_ack_i;
    assign md_done_any    = md_done_i | md_done_q_reg;
    assign pc_jump_addr_o = jump_addr_i;
    assign md_abort_o     = md_abort_reg;
    assign stall_cnt_o    = stall_cnt_reg;

    always_comb begin
        hold_pc_o      = 1'b0;
        pc_jump_en_o   = 1'b0;
        hold_if_id_o   = HC_NORMAL;
        hold_id_ex_o   = HC_NORMAL;
        hold_ex_mem_o  = HC_NORMAL;
        hold_mem_wb_o  = HC_NORMAL;
        state_next     = state_reg;
        md_timer_next  = md_timer_reg;
        md_done_q_next = 1'b0;
        md_abort_next  = 1'b0;

        if (mem_wait) begin
            // Everything upstream of MEM freezes; a completion seen now must survive the wait.
            hold_pc_o      = 1'b1;
            hold_if_id_o   = HC_HOLD;
            hold_id_ex_o   = HC_HOLD;
            hold_ex_mem_o  = HC_HOLD;
            hold_mem_wb_o  = HC_FLUSH;
            md_done_q_next = md_done_q_reg | md_done_i;
        end else begin
            case (state_reg)
                ST_MD_BUSY: begin
                    hold_pc_o     = 1'b1;
                    hold_if_id_o  = HC_HOLD;
                    hold_id_ex_o  = HC_HOLD;
                    hold_ex_mem_o = HC_FLUSH;
                    md_timer_next = md_timer_reg + 16'd1;
                    if (md_done_any) begin
                        hold_ex_mem_o = HC_NORMAL;
                        state_next    = ST_RUN;
                        md_timer_next = 16'd0;
                    end else if (md_timer_reg == TIMER_LAST) begin
                        md_abort_next = 1'b1;
                        state_next    = ST_RUN;
                        md_timer_next = 16'd0;
                    end
                end
                default: begin
                    if (state_reg == ST_RUN && md_start_i) begin
                        // A unit that answers in the issue cycle needs no stall at all.
                        if (!md_done_any) begin
                            hold_pc_o     = 1'b1;
                            hold_if_id_o  = HC_HOLD;
                            hold_id_ex_o  = HC_HOLD;
                            hold_ex_mem_o = HC_FLUSH;
                            state_next    = ST_MD_BUSY;
                            md_timer_next = 16'd0;
                        end
                    end else if (jump_en_i) begin
                        pc_jump_en_o = 1'b1;
                        hold_if_id_o = HC_FLUSH;
                        hold_id_ex_o = HC_FLUSH;
                        state_next   = (IMEM_LAT != 0) ? ST_JFLUSH : ST_RUN;
                    end else if (state_reg == ST_JFLUSH) begin
                        hold_if_id_o = HC_FLUSH;
                        state_next   = ST_RUN;
                    end else if (load_use_i) begin
                        hold_pc_o    = 1'b1;
                        hold_if_id_o = HC_HOLD;
                        hold_id_ex_o = HC_FLUSH;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_RUN;
            md_timer_reg  <= 16'd0;
            md_done_q_reg <= 1'b0;
            md_abort_reg  <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            md_timer_reg  <= md_timer_next;
            md_done_q_reg <= md_done_q_next;
            md_abort_reg  <= md_abort_next;
            if (cnt_clr_i) begin
                stall_cnt_reg <= '0;
            end else if (hold_pc_o && !(&stall_cnt_reg)) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed self-checking bench for pipe_hold_ctrl (MD_TIMEOUT=8, IMEM_LAT=1, CNT_W=4).
module tb_pipe_hold_ctrl;

    logic        clk;
    logic        rst;
    logic        jump_en_i;
    logic [63:0] jump_addr_i;
    logic        load_use_i;
    logic        md_start_i;
    logic        md_done_i;
    logic        mem_req_i;
    logic        mem_ack_i;
    logic        cnt_clr_i;
    logic        hold_pc_o;
    logic        pc_jump_en_o;
    logic [63:0] pc_jump_addr_o;
    logic [1:0]  hold_if_id_o;
    logic [1:0]  hold_id_ex_o;
    logic [1:0]  hold_ex_mem_o;
    logic [1:0]  hold_mem_wb_o;
    logic        md_abort_o;
    logic [3:0]  stall_cnt_o;

    int checks = 0;
    int errors = 0;
    int busy;

    pipe_hold_ctrl #(
        .MD_TIMEOUT(8),
        .IMEM_LAT  (1),
        .CNT_W     (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .load_use_i    (load_use_i),
        .md_start_i    (md_start_i),
        .md_done_i     (md_done_i),
        .mem_req_i     (mem_req_i),
        .mem_ack_i     (mem_ack_i),
        .cnt_clr_i     (cnt_clr_i),
        .hold_pc_o     (hold_pc_o),
        .pc_jump_en_o  (pc_jump_en_o),
        .pc_jump_addr_o(pc_jump_addr_o),
        .hold_if_id_o  (hold_if_id_o),
        .hold_id_ex_o  (hold_id_ex_o),
        .hold_ex_mem_o (hold_ex_mem_o),
        .hold_mem_wb_o (hold_mem_wb_o),
        .md_abort_o    (md_abort_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compares {hold_pc, pc_jump_en, if_id, id_ex, ex_mem, mem_wb} in one shot.
    task automatic chk_out(input string tag, input logic pc, input logic jen,
                           input logic [1:0] a, input logic [1:0] b,
                           input logic [1:0] c, input logic [1:0] d);
        logic [9:0] obs;
        logic [9:0] exp;
        obs = {hold_pc_o, pc_jump_en_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o, hold_mem_wb_o};
        exp = {pc, jen, a, b, c, d};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        $display("step %-16s pc=%b jen=%b if_id=%b id_ex=%b ex_mem=%b mem_wb=%b abort=%b cnt=%0d",
                 tag, hold_pc_o, pc_jump_en_o, hold_if_id_o, hold_id_ex_o,
                 hold_ex_mem_o, hold_mem_wb_o, md_abort_o, stall_cnt_o);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        jump_en_i = 1'b0; jump_addr_i = 64'd0; load_use_i = 1'b0;
        md_start_i = 1'b0; md_done_i = 1'b0; mem_req_i = 1'b0;
        mem_ack_i = 1'b0; cnt_clr_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1 chk_out("reset_codes", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        chk("reset_cnt", 64'(stall_cnt_o), 64'd0);
        chk("reset_abort", 64'(md_abort_o), 64'd0);
        @(negedge clk); rst = 1'b1;

        // Jump with one extra flush cycle
        @(negedge clk); jump_en_i = 1'b1; jump_addr_i = 64'h8000_0040;
        #1 chk_out("jump_c0", 0, 1, 2'b10, 2'b10, 2'b00, 2'b00);
        chk("jump_addr", pc_jump_addr_o, 64'h8000_0040);
        @(negedge clk); jump_en_i = 1'b0;
        #1 chk_out("jump_c1", 0, 0, 2'b10, 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        #1 chk_out("jump_c2", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        chk("jump_cnt", 64'(stall_cnt_o), 64'd0);

        // Mul/div done 5 cycles after start
        @(negedge clk); md_start_i = 1'b1;
        #1 chk_out("md_start", 1, 0, 2'b01, 2'b01, 2'b10, 2'b00);
        @(negedge clk); md_start_i = 1'b0;
        for (int i = 1; i < 5; i++) begin
            #1 chk_out("md_busy", 1, 0, 2'b01, 2'b01, 2'b10, 2'b00);
            @(negedge clk);
        end
        md_done_i = 1'b1;
        #1 chk_out("md_done", 1, 0, 2'b01, 2'b01, 2'b00, 2'b00);
        @(negedge clk); md_done_i = 1'b0;
        #1 chk_out("md_after", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        chk("md_cnt", 64'(stall_cnt_o), 64'd6);

        // Counter clear while idle
        @(negedge clk); cnt_clr_i = 1'b1;
        @(negedge clk); cnt_clr_i = 1'b0;
        #1 chk("clr_idle", 64'(stall_cnt_o), 64'd0);

        // Zero-latency mul/div: no stall
        @(negedge clk); md_start_i = 1'b1; md_done_i = 1'b1;
        #1 chk_out("md_zero_lat", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        @(negedge clk); md_start_i = 1'b0; md_done_i = 1'b0;
        #1 chk_out("md_zero_after", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);

        // Mul/div timeout: 8 busy cycles then a one-cycle abort
        @(negedge clk); md_start_i = 1'b1;
        #1 chk_out("to_start", 1, 0, 2'b01, 2'b01, 2'b10, 2'b00);
        @(negedge clk); md_start_i = 1'b0;
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (hold_pc_o !== 1'b1) break;
            chk_out("to_busy", 1, 0, 2'b01, 2'b01, 2'b10, 2'b00);
            busy++;
            @(negedge clk);
        end
        chk("to_busy_count", 64'(busy), 64'd8);
        chk("to_abort", 64'(md_abort_o), 64'd1);
        chk_out("to_abort_codes", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        #1 chk("to_abort_end", 64'(md_abort_o), 64'd0);

        // Memory wait inside MD_BUSY with done arriving during the wait
        @(negedge clk); md_start_i = 1'b1;
        #1 chk_out("mw_start", 1, 0, 2'b01, 2'b01, 2'b10, 2'b00);
        @(negedge clk); md_start_i = 1'b0; mem_req_i = 1'b1; mem_ack_i = 1'b0;
        #1 chk_out("mw_wait1", 1, 0, 2'b01, 2'b01, 2'b01, 2'b10);
        @(negedge clk); md_done_i = 1'b1;
        #1 chk_out("mw_wait2", 1, 0, 2'b01, 2'b01, 2'b01, 2'b10);
        @(negedge clk); md_done_i = 1'b0;
        #1 chk_out("mw_wait3", 1, 0, 2'b01, 2'b01, 2'b01, 2'b10);
        @(negedge clk); mem_ack_i = 1'b1;
        #1 chk_out("mw_ack", 1, 0, 2'b01, 2'b01, 2'b00, 2'b00);
        @(negedge clk); mem_req_i = 1'b0; mem_ack_i = 1'b0;
        #1 chk_out("mw_run", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        chk("mw_no_abort", 64'(md_abort_o), 64'd0);

        // Load-use together with a jump, then load-use alone
        @(negedge clk); jump_en_i = 1'b1; load_use_i = 1'b1; jump_addr_i = 64'h0000_1234_5678_9ABC;
        #1 chk_out("lu_jump", 0, 1, 2'b10, 2'b10, 2'b00, 2'b00);
        chk("lu_jump_addr", pc_jump_addr_o, 64'h0000_1234_5678_9ABC);
        @(negedge clk); jump_en_i = 1'b0; load_use_i = 1'b0;
        #1 chk_out("lu_jflush", 0, 0, 2'b10, 2'b00, 2'b00, 2'b00);
        @(negedge clk); load_use_i = 1'b1;
        #1 chk_out("lu_alone", 1, 0, 2'b01, 2'b10, 2'b00, 2'b00);
        @(negedge clk); load_use_i = 1'b0;
        #1 chk_out("lu_after", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);

        // Saturation after 20 stall cycles
        @(negedge clk); cnt_clr_i = 1'b1;
        @(negedge clk); cnt_clr_i = 1'b0; load_use_i = 1'b1;
        repeat (20) @(negedge clk);
        load_use_i = 1'b0;
        #1 chk("cnt_sat", 64'(stall_cnt_o), 64'd15);
        @(negedge clk);
        #1 chk("cnt_sat_hold", 64'(stall_cnt_o), 64'd15);

        // Clear wins over a stall increment
        @(negedge clk); load_use_i = 1'b1; cnt_clr_i = 1'b1;
        @(negedge clk); cnt_clr_i = 1'b0;
        #1 chk("cnt_clr_stall", 64'(stall_cnt_o), 64'd0);
        @(negedge clk); load_use_i = 1'b0;
        #1 chk("cnt_after_clr", 64'(stall_cnt_o), 64'd1);

        // Asynchronous reset in the middle of MD_BUSY
        @(negedge clk); md_start_i = 1'b1;
        @(negedge clk); md_start_i = 1'b0;
        @(negedge clk);
        #1 chk_out("rst_busy", 1, 0, 2'b01, 2'b01, 2'b10, 2'b00);
        #1 rst = 1'b0;
        #1 chk_out("rst_codes", 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        chk("rst_cnt", 64'(stall_cnt_o), 64'd0);
        chk("rst_abort", 64'(md_abort_o), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1 chk("rst_no_abort", 64'({md_abort_o, hold_pc_o}), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
